uart_top: RTL and testbench



---
 rtl/uart_top.sv | 177 +++++++++++++++++
 tb/tb_uart_top.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// UART echo: 8N1 bytes received on rs232_rx are retransmitted unchanged on rs232_tx.
// Define UART_RX_MAJORITY_EN to take each RX sample as a 2-of-3 vote around mid-bit.
module uart_top #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic rs232_tx
);
    localparam int BIT_DIV  = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int CNT_W    = $clog2(BIT_DIV + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_POS = HALF_DIV;
`else
    localparam int START_POS = HALF_DIV - 1;
`endif
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_POS);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
    state_e           rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [7:0]       buf_data_q, buf_data_d;
    logic             buf_full_q, buf_full_d;
    logic             tx_q, tx_d;
    logic             rx_sample;

`ifdef UART_RX_MAJORITY_EN
    logic rx_s4_q, rx_s4_d;
    // Decision one clock after mid-bit: s2/s3/s4 hold mid+1, mid, mid-1.
    assign rx_sample = (rx_s2_q & rx_s3_q) | (rx_s2_q & rx_s4_q) | (rx_s3_q & rx_s4_q);
`else
    assign rx_sample = rx_s2_q;
`endif

    assign rs232_tx = tx_q;

    always_comb begin
        rx_s1_d    = rs232_rx;
        rx_s2_d    = rx_s1_q;
        rx_s3_d    = rx_s2_q;
`ifdef UART_RX_MAJORITY_EN
        rx_s4_d    = rx_s3_q;
`endif
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;

        // TX is evaluated first so a same-cycle RX write re-fills the buffer.
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (buf_full_q) begin
                    tx_shift_d = buf_data_q;
                    buf_full_d = 1'b0;
                    tx_state_d = ST_START;
                    tx_d       = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            default: begin
                if (tx_cnt_q == BIT_LAST) tx_state_d = ST_IDLE;
            end
        endcase

        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                // A falling edge is required, so after a framing error the
                // line must first return high before a new frame is accepted.
                if (rx_s3_q && !rx_s2_q) rx_state_d = ST_START;
            end
            ST_START: begin
                if (rx_cnt_q == START_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sample ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sample, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_sample) begin
                        buf_data_d = rx_shift_q;
                        buf_full_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            rx_s4_q    <= 1'b1;
`endif
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
        end else begin
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_s3_q    <= rx_s3_d;
`ifdef UART_RX_MAJORITY_EN
            rx_s4_q    <= rx_s4_d;
`endif
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
        end
    end
endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top at a scaled baud (8 clocks per bit): drives 8N1 frames,
// decodes rs232_tx with an independent line monitor and compares against expected bytes.
`timescale 1ns/1ps
module tb_uart_top;
    localparam int CLK_FREQ = 800;
    localparam int BAUD     = 100;
    localparam int BIT_DIV  = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BIT_DIV / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rs232_rx = 1'b1;
    logic rs232_tx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stop_cyc = 0;
    logic mon_en = 1'b0;

    logic [8:0] obs_q[$];     // {stop_ok, data} as decoded from rs232_tx
    int         obs_cyc_q[$]; // cycle at which each echo's start bit was seen
    logic [7:0] exp_q[$];

    uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .rs232_tx(rs232_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin : tx_monitor
        logic [7:0] d;
        int fall;
        @(negedge clk);
        if (mon_en && rst_n && rs232_tx === 1'b0) begin
            fall = cyc;
            repeat (BIT_DIV / 2) @(negedge clk);
            if (rs232_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_DIV) @(negedge clk);
                    d[i] = rs232_tx;
                end
                repeat (BIT_DIV) @(negedge clk);
                obs_q.push_back({rs232_tx === 1'b1, d});
                obs_cyc_q.push_back(fall);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rs232_rx = 1'b0;
        repeat (BIT_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BIT_DIV) @(negedge clk);
        end
        stop_cyc = cyc;
        rs232_rx = stop_bit;
        repeat (BIT_DIV) @(negedge clk);
        rs232_rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rs232_rx = 1'b1;
        repeat (n * BIT_DIV) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rs232_rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3 * BIT_DIV; i++) begin
            @(negedge clk);
            total++;
            if (rs232_tx !== 1'b1) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d tx=%b required 1", i, rs232_tx);
            end
        end
    endtask

    task automatic test_single();
        int lat;
        obs_q.delete(); obs_cyc_q.delete();
        send_byte(8'hA5, 1'b1);
        idle_bits(14);
        total++;
        if (obs_q.size() != 1) begin
            bad++;
            $display("FAIL single_count: got %0d echoes required 1", obs_q.size());
        end else begin
            total++;
            if (obs_q[0] !== 9'h1A5) begin
                bad++;
                $display("FAIL single_data: got %h required 1a5", obs_q[0]);
            end
            lat = obs_cyc_q[0] - stop_cyc;
            total++;
            if (lat <= BIT_DIV / 2 || lat > BIT_DIV / 2 + HALF_DIV + 3) begin
                bad++;
                $display("FAIL single_latency: start edge %0d clks after stop drive, required %0d..%0d",
                         lat, BIT_DIV / 2 + 1, BIT_DIV / 2 + HALF_DIV + 3);
            end
        end
    endtask

    task automatic test_traversal();
        obs_q.delete(); exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            send_byte(8'(v), 1'b1);
            exp_q.push_back(8'(v));
            idle_bits(6);
        end
        idle_bits(14);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL traversal_count: got %0d echoes required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== {1'b1, exp_q[i]}) begin
                bad++;
                $display("FAIL traversal_data[%0d]: got %h required %h", i, obs_q[i], {1'b1, exp_q[i]});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        obs_q.delete(); exp_q.delete();
        for (int n = 0; n < 50; n++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
            exp_q.push_back(b);
            idle_bits(5);
        end
        idle_bits(14);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL random_count: got %0d echoes required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== {1'b1, exp_q[i]}) begin
                bad++;
                $display("FAIL random_data[%0d]: got %h required %h", i, obs_q[i], {1'b1, exp_q[i]});
            end
        end
    endtask

    task automatic test_glitch();
        int tx_low;
        obs_q.delete();
        tx_low = 0;
        @(negedge clk);
        rs232_rx = 1'b0;
        repeat (HALF_DIV / 2) @(negedge clk);
        rs232_rx = 1'b1;
        for (int i = 0; i < 20 * BIT_DIV; i++) begin
            @(negedge clk);
            if (rs232_tx !== 1'b1) tx_low++;
        end
        total++;
        if (tx_low != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_quiet: tx low for %0d clks, %0d echoes, required 0 and 0", tx_low, obs_q.size());
        end
        send_byte(8'h3C, 1'b1);
        idle_bits(14);
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== 9'h13C) begin
            bad++;
            $display("FAIL glitch_next: got %0d echoes first=%h required 1 echo of 13c",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
        end
    endtask

    task automatic test_framing();
        obs_q.delete();
        send_byte(8'h55, 1'b0);
        idle_bits(14);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL framing_drop: got %0d echoes first=%h required 0", obs_q.size(), obs_q[0]);
        end
        obs_q.delete();
        send_byte(8'h0F, 1'b1);
        idle_bits(14);
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== 9'h10F) begin
            bad++;
            $display("FAIL framing_next: got %0d echoes first=%h required 1 echo of 10f",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        int tx_low;
        budget = 0;
        tx_low = 0;
        send_byte(8'h81, 1'b1);
        while (rs232_tx !== 1'b0 && budget < 4 * BIT_DIV) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (rs232_tx !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_start: tx=%b after %0d clks, required 0 (echo start)", rs232_tx, budget);
        end
        repeat (3 * BIT_DIV) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (rs232_tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_tx: tx=%b one clk into reset, required 1", rs232_tx);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20 * BIT_DIV; i++) begin
            @(negedge clk);
            if (rs232_tx !== 1'b1) tx_low++;
        end
        total++;
        if (tx_low != 0) begin
            bad++;
            $display("FAIL reset_mid_residual: tx low for %0d clks after reset, required 0", tx_low);
        end
        obs_q.delete();
        send_byte(8'h42, 1'b1);
        idle_bits(14);
        total++;
        if (obs_q.size() != 1 || obs_q[0] !== 9'h142) begin
            bad++;
            $display("FAIL reset_mid_recover: got %0d echoes first=%h required 1 echo of 142",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 9'h0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        idle_bits(2);
        test_single();
        test_traversal();
        test_random();
        test_glitch();
        test_framing();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
